// File: rtl/regfile_cmd_master_pkg.sv
// Shared encodings for the register-file command master: op codes, FSM states, default widths.
package regfile_cmd_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_B = 3'd3,
        WR_A = 3'd4,
        RESP = 3'd5
    } fsmStateT;

endpackage

// File: rtl/regfile_cmd_master.sv
// Command-driven READ/WRITE/COPY/SWAP initiator for the register file.
// SWAP support is built only when REGFILE_CMD_MASTER_SWAP_EN is defined; otherwise op 11 answers with rsp_err.
module regfile_cmd_master
    import regfile_cmd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ReadRegNum,
    input  logic [DATA_W-1:0] ReadData,
    output logic [ADDR_W-1:0] WriteRegNum,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite
);

    fsmStateT          state;
    logic [1:0]        opR;
    logic [ADDR_W-1:0] raR;
    logic [ADDR_W-1:0] rbR;
    logic [DATA_W-1:0] dataR;
    logic [DATA_W-1:0] tmpA;
`ifdef REGFILE_CMD_MASTER_SWAP_EN
    logic [DATA_W-1:0] tmpB;
`endif

    // Handshake and status decodes taken straight from the state register.
    assign cmd_ready = (state == IDLE) && !Reset;
    assign busy      = (state != IDLE);

    // Command FSM with registered register-file and response outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            opR         <= 2'b00;
            raR         <= '0;
            rbR         <= '0;
            dataR       <= '0;
            tmpA        <= '0;
`ifdef REGFILE_CMD_MASTER_SWAP_EN
            tmpB        <= '0;
`endif
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            ReadRegNum  <= '0;
            WriteRegNum <= '0;
            WriteData   <= '0;
            RegWrite    <= 1'b0;
        end else begin
            RegWrite    <= 1'b0;
            WriteRegNum <= '0;
            WriteData   <= '0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        opR        <= cmd_op;
                        raR        <= cmd_ra;
                        rbR        <= cmd_rb;
                        dataR      <= cmd_data;
                        ReadRegNum <= cmd_ra;
                        if (cmd_op == OP_WRITE) begin
                            state       <= WR_A;
                            RegWrite    <= 1'b1;
                            WriteRegNum <= cmd_ra;
                            WriteData   <= cmd_data;
                        end else begin
                            // An unsupported SWAP also spends one cycle here so its error answer keeps the 1-cycle latency.
                            state <= RD_A;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_A: begin
                    case (opR)
                        OP_READ: begin
                            tmpA      <= ReadData;
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= ReadData;
                            rsp_err   <= 1'b0;
                        end
                        OP_COPY: begin
                            tmpA        <= ReadData;
                            state       <= WR_B;
                            RegWrite    <= 1'b1;
                            WriteRegNum <= rbR;
                            WriteData   <= ReadData;
                        end
`ifdef REGFILE_CMD_MASTER_SWAP_EN
                        OP_SWAP: begin
                            tmpA       <= ReadData;
                            state      <= RD_B;
                            ReadRegNum <= rbR;
                        end
`endif
                        default: begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                        end
                    endcase
                end
`ifdef REGFILE_CMD_MASTER_SWAP_EN
                RD_B: begin
                    tmpB        <= ReadData;
                    ReadRegNum  <= raR;
                    state       <= WR_B;
                    RegWrite    <= 1'b1;
                    WriteRegNum <= rbR;
                    WriteData   <= tmpA;
                end
`endif
                WR_B: begin
`ifdef REGFILE_CMD_MASTER_SWAP_EN
                    if (opR == OP_SWAP) begin
                        state       <= WR_A;
                        RegWrite    <= 1'b1;
                        WriteRegNum <= raR;
                        WriteData   <= tmpB;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= tmpA;
                        rsp_err   <= 1'b0;
                    end
`else
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= tmpA;
                    rsp_err   <= 1'b0;
`endif
                end
                WR_A: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= (opR == OP_WRITE) ? dataR : tmpA;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end else begin
                        state <= RESP;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed self-checking bench for regfile_cmd_master with a preloading register-file responder.
module tb_regfile_cmd_master;
    import regfile_cmd_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          Reset = 1'b0;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy, RegWrite;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_ra, cmd_rb, ReadRegNum, WriteRegNum;
    logic [DW-1:0] cmd_data, rsp_data, ReadData, WriteData;

    logic [DW-1:0] regs [0:7];
    int nVec = 0;
    int nErr = 0;
    int wrCount = 0;
    int accCount = 0;
    logic [AW-1:0] lastWrNum;
    logic [DW-1:0] lastWrData;

    always #5 clk = ~clk;

    regfile_cmd_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .ReadRegNum(ReadRegNum), .ReadData(ReadData),
        .WriteRegNum(WriteRegNum), .WriteData(WriteData), .RegWrite(RegWrite)
    );

    // Register file responder: preloads r_n = n on Reset.
    assign ReadData = regs[ReadRegNum];
    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= DW'(i);
        end else if (RegWrite) begin
            regs[WriteRegNum] <= WriteData;
        end
    end

    // Edge monitor: counts register writes and command accepts.
    always @(posedge clk) begin
        if (!Reset) begin
            if (RegWrite) begin
                wrCount++;
                lastWrNum  = WriteRegNum;
                lastWrData = WriteData;
            end
            if (cmd_valid && cmd_ready) accCount++;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one command, wait for acceptance; returns with cmd_valid dropped, #1 after the accept edge.
    task automatic sendCmd(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [DW-1:0] d);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_data = d;
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) checkVal("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_ra = ~ra; cmd_rb = ~rb; cmd_data = ~d;
    endtask

    task automatic doCmd(input logic [1:0] op, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                         input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic re,
                         output int lat, output int nw);
        int w0;
        w0 = wrCount;
        rsp_ready = 1'b1;
        sendCmd(op, ra, rb, d);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) checkVal("rsp_timeout", 32'd0, 32'd1);
        rd = rsp_data;
        re = rsp_err;
        @(posedge clk);
        #1;
        nw = wrCount - w0;
    endtask

    logic [DW-1:0] rd;
    logic          re;
    int            lat, nw, a0, w0;

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ra = '0; cmd_rb = '0; cmd_data = '0; rsp_ready = 1'b0;
        #2 Reset = 1'b1;
        #20;
        checkVal("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkVal("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_regwrite", 32'(RegWrite), 32'd0);
        checkVal("rst_wr_num_data", {16'd0, 8'(WriteRegNum), WriteData}, 32'd0);
        checkVal("rst_read_num", 32'(ReadRegNum), 32'd0);
        checkVal("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        #1 checkVal("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        doCmd(OP_READ, 3'd5, 3'd0, 8'h00, rd, re, lat, nw);
        checkVal("read5_data", 32'(rd), 32'h05);
        checkVal("read5_err", 32'(re), 32'd0);
        checkVal("read5_lat", 32'(lat), 32'd1);
        checkVal("read5_nwr", 32'(nw), 32'd0);
        checkVal("read5_rsp_dropped", 32'(rsp_valid), 32'd0);

        doCmd(OP_WRITE, 3'd3, 3'd0, 8'hA5, rd, re, lat, nw);
        checkVal("write3_data", 32'(rd), 32'hA5);
        checkVal("write3_lat", 32'(lat), 32'd1);
        checkVal("write3_nwr", 32'(nw), 32'd1);
        checkVal("write3_wrnum", 32'(lastWrNum), 32'd3);
        checkVal("write3_wrdata", 32'(lastWrData), 32'hA5);
        doCmd(OP_READ, 3'd3, 3'd0, 8'h00, rd, re, lat, nw);
        checkVal("read3_data", 32'(rd), 32'hA5);

        doCmd(OP_COPY, 3'd6, 3'd1, 8'h00, rd, re, lat, nw);
        checkVal("copy61_data", 32'(rd), 32'h06);
        checkVal("copy61_lat", 32'(lat), 32'd2);
        checkVal("copy61_nwr", 32'(nw), 32'd1);
        checkVal("copy61_wrnum", 32'(lastWrNum), 32'd1);
        checkVal("copy61_r1", 32'(regs[1]), 32'h06);

        doCmd(OP_SWAP, 3'd2, 3'd7, 8'h00, rd, re, lat, nw);
`ifdef REGFILE_CMD_MASTER_SWAP_EN
        checkVal("swap27_data", 32'(rd), 32'h02);
        checkVal("swap27_err", 32'(re), 32'd0);
        checkVal("swap27_lat", 32'(lat), 32'd4);
        checkVal("swap27_nwr", 32'(nw), 32'd2);
        checkVal("swap27_r2", 32'(regs[2]), 32'h07);
        checkVal("swap27_r7", 32'(regs[7]), 32'h02);
        doCmd(OP_SWAP, 3'd5, 3'd5, 8'h00, rd, re, lat, nw);
        checkVal("swap55_data", 32'(rd), 32'h05);
        checkVal("swap55_nwr", 32'(nw), 32'd2);
        checkVal("swap55_r5", 32'(regs[5]), 32'h05);
`else
        checkVal("swap27_data", 32'(rd), 32'h00);
        checkVal("swap27_err", 32'(re), 32'd1);
        checkVal("swap27_lat", 32'(lat), 32'd1);
        checkVal("swap27_nwr", 32'(nw), 32'd0);
        checkVal("swap27_r2", 32'(regs[2]), 32'h02);
        checkVal("swap27_r7", 32'(regs[7]), 32'h07);
`endif

        doCmd(OP_COPY, 3'd4, 3'd4, 8'h00, rd, re, lat, nw);
        checkVal("copy44_data", 32'(rd), 32'h04);
        checkVal("copy44_nwr", 32'(nw), 32'd1);
        checkVal("copy44_r4", 32'(regs[4]), 32'h04);

        // Backpressure: READ r1 (0x06) with rsp_ready low and cmd_valid held.
        rsp_ready = 1'b0;
        a0 = accCount;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_ra = 3'd1; cmd_rb = 3'd0; cmd_data = 8'h00;
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkVal("bp_rsp_data", 32'(rsp_data), 32'h06);
            checkVal("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        checkVal("bp_accepts", 32'(accCount - a0), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkVal("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
        checkVal("bp_accepts_hs", 32'(accCount - a0), 32'd1);
        @(negedge clk);
        checkVal("bp_second_accept", 32'(accCount - a0), 32'd2);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkVal("bp_second_data", 32'(rsp_data), 32'h06);
        @(negedge clk);
        checkVal("bp_idle", 32'(busy), 32'd0);

        // Reset in mid-command: registers return to preload and nothing more is written.
`ifdef REGFILE_CMD_MASTER_SWAP_EN
        sendCmd(OP_SWAP, 3'd2, 3'd7, 8'h00);
        @(posedge clk);
        #1 checkVal("mid_rdb_readnum", 32'(ReadRegNum), 32'd7);
`else
        sendCmd(OP_COPY, 3'd5, 3'd0, 8'h00);
        @(posedge clk);
        #1 checkVal("mid_wrb_regwrite", 32'(RegWrite), 32'd1);
`endif
        Reset = 1'b1;
        #1;
        checkVal("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        checkVal("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkVal("mid_rst_busy", 32'(busy), 32'd0);
        checkVal("mid_rst_r3", 32'(regs[3]), 32'h03);
        checkVal("mid_rst_r1", 32'(regs[1]), 32'h01);
        @(negedge clk);
        Reset = 1'b0;
        w0 = wrCount;
        repeat (4) @(negedge clk);
        checkVal("post_rst_no_write", 32'(wrCount - w0), 32'd0);
        checkVal("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        doCmd(OP_READ, 3'd7, 3'd0, 8'h00, rd, re, lat, nw);
        checkVal("post_rst_read7", 32'(rd), 32'h07);
        checkVal("post_rst_r0", 32'(regs[0]), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
